// File: rtl/norm_shift_ctrl.sv
// Normalizing left-shifter for a 27-bit mantissa: shifts by up to two bits per
// cycle until the hidden bit is set, the value is zero, or the exponent floor (1) is reached.
module norm_shift_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] mant_in,
  input  logic [7:0]  exp_in,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] mant_out,
  output logic [7:0]  exp_out,
  output logic [4:0]  shift_cnt,
  output logic        zero_flag,
  output logic        denorm_flag,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // out_valid stays high and outputs stay stable until out_ready is seen.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [26:0] m_q, m_d;
  logic [7:0]  e_q, e_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        zf_q, zf_d;
  logic        df_q, df_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      zf_q    <= 1'b0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      zf_q    <= zf_d;
      df_q    <= df_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    zf_d    = zf_q;
    df_d    = df_q;
    case (state_q)
      IDLE: begin
        // abort in IDLE only suppresses acceptance on this edge
        if (in_valid && !abort) begin
          state_d = NORM;
          m_d     = mant_in;
          e_d     = exp_in;
          cnt_d   = '0;
          zf_d    = 1'b0;
          df_d    = 1'b0;
        end
      end
      NORM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (m_q == '0) begin
          zf_d    = 1'b1;
          e_d     = '0;
          state_d = DONE;
        end else if (m_q[26]) begin
          state_d = DONE;
        end else if (m_q[26:25] == 2'b00 && e_q >= 8'd3) begin
          m_d   = {m_q[24:0], 2'b00};
          e_d   = e_q - 8'd2;
          cnt_d = cnt_q + 5'd2;
        end else if (e_q >= 8'd2) begin
          // m_q[26] is known clear here, so no set bit is lost
          m_d   = {m_q[25:0], 1'b0};
          e_d   = e_q - 8'd1;
          cnt_d = cnt_q + 5'd1;
        end else begin
          df_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign mant_out    = m_q;
  assign exp_out     = e_q;
  assign shift_cnt   = cnt_q;
  assign zero_flag   = zf_q;
  assign denorm_flag = df_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed bench for norm_shift_ctrl: hand-computed results, latency, hold,
// abort and asynchronous reset behaviour.
module tb_norm_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] mant_in = '0;
  logic [7:0]  exp_in = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [26:0] mant_out;
  logic [7:0]  exp_out;
  logic [4:0]  shift_cnt;
  logic        zero_flag;
  logic        denorm_flag;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // {mant, exp, shift_cnt, zero_flag, denorm_flag}
  logic [41:0] exp_q[$];

  norm_shift_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .exp_in(exp_in), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .mant_out(mant_out), .exp_out(exp_out),
    .shift_cnt(shift_cnt), .zero_flag(zero_flag), .denorm_flag(denorm_flag),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mant"}, 32'(mant_out), 32'd0);
    check({tag, "_exp"}, 32'(exp_out), 32'd0);
    check({tag, "_cnt"}, 32'(shift_cnt), 32'd0);
    check({tag, "_flags"}, 32'({zero_flag, denorm_flag}), 32'd0);
  endtask

  // driver: offer an operand, leave it accepted on the next edge
  task automatic start_op(input logic [26:0] m, input logic [7:0] e);
    @(negedge clk);
    mant_in  = m;
    exp_in   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_cnt_clr", 32'(shift_cnt), 32'd0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result();
    logic [41:0] want;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("mant_out", 32'(mant_out), 32'(want[41:15]));
      check("exp_out", 32'(exp_out), 32'(want[14:7]));
      check("shift_cnt", 32'(shift_cnt), 32'(want[6:2]));
      check("zero_flag", 32'(zero_flag), 32'(want[1]));
      check("denorm_flag", 32'(denorm_flag), 32'(want[0]));
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input logic [26:0] m, input logic [7:0] e,
                        input logic [26:0] em, input logic [7:0] ee, input logic [4:0] ec,
                        input logic ez, input logic ed, input int lat);
    int n;
    exp_q.push_back({em, ee, ec, ez, ed});
    start_op(m, e);
    wait_valid(n);
    check("latency", 32'(n), 32'(lat));
    check_result();
    handoff();
  endtask

  initial begin
    int  n;
    logic seen;

    #2;
    check_idle_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //      mant_in        exp   mant_out      exp  cnt  z  d  latency
    run_op(27'h4000000, 8'd100, 27'h4000000, 8'd100, 5'd0,  0, 0, 1);
    run_op(27'h0400000, 8'd100, 27'h4000000, 8'd96,  5'd4,  0, 0, 3);
    run_op(27'h0000001, 8'd127, 27'h4000000, 8'd101, 5'd26, 0, 0, 14);
    run_op(27'h0000000, 8'd50,  27'h0000000, 8'd0,   5'd0,  1, 0, 1);
    run_op(27'h0100000, 8'd4,   27'h0800000, 8'd1,   5'd3,  0, 1, 3);
    run_op(27'h2000000, 8'd10,  27'h4000000, 8'd9,   5'd1,  0, 0, 2);
    run_op(27'h0000003, 8'd1,   27'h0000003, 8'd1,   5'd0,  0, 1, 1);
    run_op(27'h0000001, 8'd2,   27'h0000002, 8'd1,   5'd1,  0, 1, 2);
    run_op(27'h0000001, 8'd3,   27'h0000004, 8'd1,   5'd2,  0, 1, 2);
    run_op(27'h0000005, 8'd0,   27'h0000005, 8'd0,   5'd0,  0, 1, 1);

    // result held in DONE while the consumer stalls; new operands ignored
    exp_q.push_back({27'h4000000, 8'd96, 5'd4, 1'b0, 1'b0});
    start_op(27'h0400000, 8'd100);
    wait_valid(n);
    check("hold_latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mant_in  = 27'h0000123;
      exp_in   = 8'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_mant", 32'(mant_out), 32'h4000000);
      check("hold_exp", 32'(exp_out), 32'd96);
    end
    check_result();
    // in_valid high on the DONE->IDLE edge must not start a new operation
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("handoff_no_accept_busy", 32'(busy), 32'd0);
    check("handoff_no_accept_valid", 32'(out_valid), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // abort during NORM
    start_op(27'h0000001, 8'd127);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    seen |= out_valid;
    check("abort_norm_idle", 32'(in_ready), 32'd1);
    check("abort_norm_busy", 32'(busy), 32'd0);
    repeat (15) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("abort_norm_no_result", 32'(seen), 32'd0);

    // abort in DONE drops the result
    start_op(27'h4000000, 8'd20);
    wait_valid(n);
    check("abort_done_reached", 32'(out_valid), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_done_valid", 32'(out_valid), 32'd0);
    check("abort_done_idle", 32'(in_ready), 32'd1);

    // abort in IDLE blocks acceptance on that edge
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    mant_in  = 27'h4000000;
    exp_in   = 8'd5;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_no_accept", 32'(busy), 32'd0);

    // asynchronous reset mid-NORM
    start_op(27'h0000001, 8'd127);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_reset("async_reset");
    check("reset_norm_no_result", 32'(seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(27'h0400000, 8'd100, 27'h4000000, 8'd96, 5'd4, 0, 0, 3);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
